// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter in front of the 64-bit FIFO write port.
// Optional FIFO_WR_ARB_CNT_EN adds a saturating 32-bit write counter.
module fifo_wr_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_W    = 64,
  parameter int MAX_BURST = 4
) (
  input  logic                      clk,
  input  logic                      reset_ni,
  input  logic [N_REQ-1:0]          req_valid_i,
  input  logic [N_REQ*DATA_W-1:0]   req_data_i,
  output logic [N_REQ-1:0]          req_ready_o,
  input  logic                      wr_rst_busy_i,
  input  logic                      full_i,
  output logic [DATA_W-1:0]         din_o,
  output logic                      wr_en_o,
  output logic [N_REQ-1:0]          grant_o,
  output logic                      busy_o,
  output logic                      drop_o
`ifdef FIFO_WR_ARB_CNT_EN
  ,
  output logic [31:0]               wr_count_o
`endif
);

  localparam int IW = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  typedef enum logic [1:0] {
    RST_WAIT,
    IDLE,
    GRANT
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [IW-1:0]     r_owner;
  logic [IW-1:0]     w_owner_nxt;
  logic [IW-1:0]     r_last;
  logic [IW-1:0]     w_last_nxt;
  logic [IW-1:0]     w_pick;
  logic              w_any;
  logic [CW-1:0]     r_cnt;
  logic [CW-1:0]     w_cnt_nxt;
  logic [N_REQ-1:0]  r_grant;
  logic [N_REQ-1:0]  w_grant_nxt;
  logic [N_REQ-1:0]  w_ready;
  logic              w_beat;
  logic              w_own_valid;
  logic [DATA_W-1:0] w_data;
  logic              r_pend;
  logic [DATA_W-1:0] r_din;

  assign w_ready = r_grant
                 & {N_REQ{(r_state == GRANT)
                          & !full_i
                          & !wr_rst_busy_i}};
  assign w_beat      = |(req_valid_i & w_ready);
  assign w_own_valid = |(req_valid_i & r_grant);

  always_comb begin
    w_data = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (r_grant[k]) w_data = req_data_i[k*DATA_W +: DATA_W];
    end
  end

  // Scan from farthest to nearest so the first valid after r_last wins.
  always_comb begin
    w_pick = r_last;
    w_any  = 1'b0;
    for (int i = N_REQ; i >= 1; i--) begin
      if (req_valid_i[(int'(r_last) + i) % N_REQ]) begin
        w_pick = IW'((int'(r_last) + i) % N_REQ);
        w_any  = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last;
    w_cnt_nxt   = r_cnt;
    w_grant_nxt = r_grant;
    if (wr_rst_busy_i) begin
      w_state_nxt = RST_WAIT;
      w_grant_nxt = '0;
      w_cnt_nxt   = '0;
    end else begin
      unique case (r_state)
        RST_WAIT: w_state_nxt = IDLE;
        IDLE: begin
          if (w_any) begin
            w_state_nxt = GRANT;
            w_owner_nxt = w_pick;
            w_grant_nxt = N_REQ'(1) << w_pick;
            w_cnt_nxt   = '0;
          end
        end
        GRANT: begin
          if (w_beat) begin
            w_cnt_nxt = CW'(r_cnt + 1'b1);
            if (w_cnt_nxt == CW'(MAX_BURST)) begin
              w_state_nxt = IDLE;
              w_last_nxt  = r_owner;
              w_grant_nxt = '0;
            end
          end else if (!w_own_valid) begin
            w_state_nxt = IDLE;
            w_last_nxt  = r_owner;
            w_grant_nxt = '0;
          end
        end
        default: w_state_nxt = RST_WAIT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      r_state <= RST_WAIT;
      r_owner <= '0;
      r_last  <= IW'(N_REQ - 1);
      r_cnt   <= '0;
      r_grant <= '0;
      r_pend  <= 1'b0;
      r_din   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_last  <= w_last_nxt;
      r_cnt   <= w_cnt_nxt;
      r_grant <= w_grant_nxt;
      r_pend  <= w_beat;
      if (w_beat) r_din <= w_data;
    end
  end

  assign req_ready_o = w_ready;
  assign grant_o     = r_grant;
  assign busy_o      = (r_state == RST_WAIT);
  assign din_o       = r_din;
  assign wr_en_o     = r_pend & !wr_rst_busy_i;
  assign drop_o      = r_pend & wr_rst_busy_i;

`ifdef FIFO_WR_ARB_CNT_EN
  logic [31:0] r_wr_count;

  always_ff @(posedge clk or negedge reset_ni) begin
    if (!reset_ni) begin
      r_wr_count <= '0;
    end else if (wr_en_o && (r_wr_count != 32'hFFFF_FFFF)) begin
      r_wr_count <= r_wr_count + 32'd1;
    end
  end

  assign wr_count_o = r_wr_count;
`endif

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter for the 64-bit FIFO. It shares the FIFO write interface (din/wr_en) among `N_REQ` requesters, each using a valid/ready handshake. It holds each grant for a bounded burst. It also keeps every requester blocked while the FIFO write side reports reset-busy, so no write reaches the FIFO during its reset window. It sits in the write clock domain, directly in front of the FIFO write port.

## Interface
- `N_REQ`, 4: number of requesters, 2..8.
- `DATA_W`, 64: data width.
- `MAX_BURST`, 4: maximum beats per grant, 1..16.

- `clk`  in  1  write-domain clock.
- `reset_ni`  in  1  asynchronous active-low reset.
- `req_valid_i`  in  N_REQ  per-requester valid.
- `req_data_i`  in  N_REQ*DATA_W  requester k data at bits [k*DATA_W +: DATA_W].
- `req_ready_o`  out  N_REQ  per-requester ready (combinational).
- `wr_rst_busy_i`  in  1  FIFO write-side reset busy.
- `full_i`  in  1  FIFO almost-full: asserted when at most one free slot remains.
- `din_o`  out  DATA_W  FIFO write data (registered).
- `wr_en_o`  out  1  FIFO write enable.
- `grant_o`  out  N_REQ  one-hot current owner; 0 when no owner.
- `busy_o`  out  1  high while in RST_WAIT.
- `drop_o`  out  1  one-cycle pulse when an accepted beat is discarded.

## Operation
- States: RST_WAIT, IDLE, GRANT.
- Reset:
  - state = RST_WAIT.
  - `last_owner` = N_REQ-1, so requester 0 has first priority.
  - `grant_o`, `din_o`, `wr_en_o`, `drop_o`, `req_ready_o` = 0.
  - `busy_o` = 1.
- RST_WAIT -> IDLE on the first cycle `wr_rst_busy_i`=0.
- IDLE, any valid high:
  - Pick the first valid index after `last_owner`, cyclically.
  - Register the one-hot grant; go to GRANT.
  - Clear the burst counter.
- Handshake: `req_ready_o[k]` = (state==GRANT) & `grant_o[k]` & !`full_i` & !`wr_rst_busy_i`.
- Beat = `req_valid_i[k]` & `req_ready_o[k]`.
  - On a beat, the next cycle has `din_o` = data and a write pending.
  - The burst counter increments on each beat.
- GRANT -> IDLE when either:
  - the owner's valid is low in a cycle with no beat, or
  - a beat brings the burst counter to MAX_BURST.
- On GRANT -> IDLE, `last_owner` = owner and `grant_o` clears.
- `full_i` high in GRANT: no beats, counter holds, grant held.
- Any state, `wr_rst_busy_i` high:
  - Next state is RST_WAIT; grant clears; the counter clears.
  - `last_owner` is unchanged.
- Pending write:
  - `wr_en_o` = pending & !`wr_rst_busy_i`.
  - If `wr_rst_busy_i` is high while a write is pending, the write is discarded and `drop_o` pulses that cycle.
- Lone requester at MAX_BURST: after release it is re-granted following one IDLE cycle.
- Only the owner's ready can be high. At most one ready bit is ever set.

## Timing
- Arbitration: valid in IDLE at cycle t -> `grant_o` at t+1 -> first possible beat at t+1.
- Write latency: beat at cycle t -> `wr_en_o`/`din_o` at t+1.
- Throughput: 1 beat/cycle within a grant; 1 idle cycle between grants.
- `full_i` must be sampled as almost-full, since one beat can be in flight.
- Async reset asserted mid-burst: all outputs go to their reset values immediately. The in-flight beat is lost and `drop_o` does not pulse.

## Configuration
- Macro: `FIFO_WR_ARB_CNT_EN`.
- Defined:
  - Adds output `wr_count_o` (32 bits), reset 0.
  - It increments on every cycle with `wr_en_o`=1 and saturates at 0xFFFFFFFF.
  - Asynchronous reset clears it; `wr_rst_busy_i` does not.
- Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- Startup:
  - Reset, then hold `wr_rst_busy_i`=1 for 20 cycles while requester 0 drives valid with data 0xABABABABABABABAB.
  - Required: `busy_o`=1 and ready=0 throughout.
  - After busy drops: grant 0001, then exactly one `wr_en_o` with that data.
- Round-robin: all 4 requesters continuously valid, MAX_BURST=4.
  - Required grant order: 0,1,2,3,0.
  - Exactly 4 consecutive `wr_en_o` per grant, with one idle cycle between grants.
- Full backpressure: requester 2 owns the grant after 1 beat; `full_i`=1 for 5 cycles.
  - Required: no `wr_en_o`, grant held, counter at 1.
  - After release: 3 more beats, then the grant is released.
- Early release: the owner drops valid after 2 beats.
  - Required: back to IDLE and `last_owner` updated; the next requester is granted one cycle later.
- FIFO re-reset mid-burst: beat at t, then `wr_rst_busy_i`=1 at t+1.
  - Required: `wr_en_o`=0 and `drop_o`=1 at t+1; state RST_WAIT and `grant_o`=0 at t+2.
- With `FIFO_WR_ARB_CNT_EN` defined: after 10 writes, `wr_count_o`=10. The value survives a `wr_rst_busy_i` pulse and clears on `reset_ni`.
